// File: rtl/hsv_pixel_sequencer.sv
// RGB-to-HSV sequencer: one pixel per handshake, hue/saturation/value from one shared radix-2 divider.
// Optional HSV_VFAST_EN: value from a multiply-shift in CALC, skipping the third division.
module hsv_pixel_sequencer #(
    parameter int DIV_W = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       h,
    output logic [7:0]       s,
    output logic [7:0]       v,
    output logic [CNT_W-1:0] pix_cnt
);
    localparam int CW = $clog2(DIV_W + 1);

    typedef enum logic [2:0] {IDLE, CALC, DIV_H, DIV_S, DIV_V, DONE} state_t;
    typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_t;

    state_t state_reg, state_next;

    logic [7:0]       r_reg, g_reg, b_reg;
    logic [7:0]       max_reg, delta_reg;
    sector_t          sector_reg;
    logic             neg_reg;
    logic [DIV_W-1:0] dvd_reg, quo_reg;
    logic [7:0]       dsr_reg, rem_reg;
    logic [CW-1:0]    cnt_reg;
    logic [8:0]       h_calc_reg;
    logic [8:0]       h_reg;
    logic [7:0]       s_reg, v_reg;
    logic [CNT_W-1:0] pix_cnt_reg;
`ifdef HSV_VFAST_EN
    logic [7:0]       vfast_reg;
`else
    logic [7:0]       s_calc_reg;
`endif

    // Sector selection, extremes and hue numerator from the captured pixel
    sector_t    sector_c;
    logic [7:0] max_c, min_c, delta_c, num_a, num_b, absnum_c;
    logic       neg_c;

    always_comb begin
        sector_c = SEC_R;
        max_c    = r_reg;
        num_a    = g_reg;
        num_b    = b_reg;
        if (r_reg >= g_reg && r_reg >= b_reg) begin
            sector_c = SEC_R;
            max_c    = r_reg;
            num_a    = g_reg;
            num_b    = b_reg;
        end else if (g_reg >= b_reg) begin
            sector_c = SEC_G;
            max_c    = g_reg;
            num_a    = b_reg;
            num_b    = r_reg;
        end else begin
            sector_c = SEC_B;
            max_c    = b_reg;
            num_a    = r_reg;
            num_b    = g_reg;
        end
        min_c = r_reg;
        if (g_reg < min_c) min_c = g_reg;
        if (b_reg < min_c) min_c = b_reg;
        delta_c  = max_c - min_c;
        neg_c    = num_a < num_b;
        absnum_c = neg_c ? (num_b - num_a) : (num_a - num_b);
    end

    // One restoring step; a zero divisor never produces a quotient bit
    logic [8:0]       rem_sh;
    logic             fits;
    logic [7:0]       rem_nx;
    logic [DIV_W-1:0] quo_nx;
    logic             div_last;

    always_comb begin
        rem_sh   = {rem_reg, dvd_reg[DIV_W-1]};
        fits     = (dsr_reg != 8'd0) && (rem_sh >= {1'b0, dsr_reg});
        rem_nx   = fits ? 8'(rem_sh - {1'b0, dsr_reg}) : rem_sh[7:0];
        quo_nx   = {quo_reg[DIV_W-2:0], fits};
        div_last = (cnt_reg == CW'(DIV_W - 1));
    end

    // Hue from the final quotient of the hue division
    logic [8:0] q9, hue_c;

    always_comb begin
        q9    = quo_nx[8:0];
        hue_c = 9'd0;
        case (sector_reg)
            SEC_G:   hue_c = neg_reg ? (9'd120 - q9) : (9'd120 + q9);
            SEC_B:   hue_c = neg_reg ? (9'd240 - q9) : (9'd240 + q9);
            default: hue_c = (neg_reg && q9 != 9'd0) ? (9'd360 - q9) : q9;
        endcase
        if (delta_reg == 8'd0) hue_c = 9'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC:  state_next = DIV_H;
            DIV_H: if (div_last) state_next = DIV_S;
`ifdef HSV_VFAST_EN
            DIV_S: if (div_last) state_next = DONE;
`else
            DIV_S: if (div_last) state_next = DIV_V;
            DIV_V: if (div_last) state_next = DONE;
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg       <= '0;
            g_reg       <= '0;
            b_reg       <= '0;
            max_reg     <= '0;
            delta_reg   <= '0;
            sector_reg  <= SEC_R;
            neg_reg     <= 1'b0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
            h_calc_reg  <= '0;
            h_reg       <= '0;
            s_reg       <= '0;
            v_reg       <= '0;
            pix_cnt_reg <= '0;
`ifdef HSV_VFAST_EN
            vfast_reg   <= '0;
`else
            s_calc_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    r_reg <= r;
                    g_reg <= g;
                    b_reg <= b;
                end
                CALC: begin
                    max_reg    <= max_c;
                    delta_reg  <= delta_c;
                    sector_reg <= sector_c;
                    neg_reg    <= neg_c;
                    dvd_reg    <= DIV_W'(absnum_c) * DIV_W'(60);
                    dsr_reg    <= delta_c;
                    rem_reg    <= '0;
                    quo_reg    <= '0;
                    cnt_reg    <= '0;
`ifdef HSV_VFAST_EN
                    vfast_reg  <= 8'(({8'd0, max_c} * 16'd101) >> 8);
`endif
                end
                DIV_H, DIV_S, DIV_V: begin
                    dvd_reg <= dvd_reg << 1;
                    rem_reg <= rem_nx;
                    quo_reg <= quo_nx;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (div_last) begin
                        // Reload the divider for the next division in the same edge
                        rem_reg <= '0;
                        quo_reg <= '0;
                        cnt_reg <= '0;
                        if (state_reg == DIV_H) begin
                            h_calc_reg <= hue_c;
                            dvd_reg    <= DIV_W'(delta_reg) * DIV_W'(100);
                            dsr_reg    <= max_reg;
                        end else if (state_reg == DIV_S) begin
`ifdef HSV_VFAST_EN
                            h_reg <= h_calc_reg;
                            s_reg <= quo_nx[7:0];
                            v_reg <= vfast_reg;
`else
                            s_calc_reg <= quo_nx[7:0];
                            dvd_reg    <= DIV_W'(max_reg) * DIV_W'(100);
                            dsr_reg    <= 8'd255;
`endif
                        end else begin
`ifndef HSV_VFAST_EN
                            h_reg <= h_calc_reg;
                            s_reg <= s_calc_reg;
                            v_reg <= quo_nx[7:0];
`endif
                        end
                    end
                end
                DONE: if (out_ready) pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign h       = h_reg;
    assign s       = s_reg;
    assign v       = v_reg;
    assign pix_cnt = pix_cnt_reg;
endmodule

// File: tb/tb_hsv_pixel_sequencer.sv
// Directed bench for hsv_pixel_sequencer: scoreboard of reference HSV results, latency, stall and reset checks.
module tb_hsv_pixel_sequencer;
`ifdef HSV_VFAST_EN
    localparam int LAT = 32;
`else
    localparam int LAT = 47;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  h;
    logic [7:0]  s, v;
    logic [15:0] pix_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [8:0] h;
        logic [7:0] s;
        logic [7:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hsv_pixel_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .h(h), .s(s), .v(v),
        .pix_cnt(pix_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t hsv_ref(input int rr, input int gg, input int bb);
        exp_t e;
        int mx, mn, d, hh;
        mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
        mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
        d = mx - mn;
        if (d == 0)        hh = 0;
        else if (rr == mx) hh = (60 * (gg - bb)) / d;
        else if (gg == mx) hh = 120 + (60 * (bb - rr)) / d;
        else               hh = 240 + (60 * (rr - gg)) / d;
        if (hh < 0) hh += 360;
        if (hh >= 360) hh -= 360;
        e.h = 9'(hh);
        e.s = (mx == 0) ? 8'd0 : 8'((d * 100) / mx);
`ifdef HSV_VFAST_EN
        e.v = 8'((mx * 101) >> 8);
`else
        e.v = 8'((mx * 100) / 255);
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, latency, result, optional stall, handshake
    task automatic run_pixel(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                             input bit stall);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 100) begin step(); n++; end
        chk("in_ready_wait", int'(in_ready), 1);
        sb.push_back(hsv_ref(int'(pr), int'(pg), int'(pb)));
        out_ready = !stall;
        r = pr; g = pg; b = pb; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin step(); n++; end
        chk("latency", n, LAT);
        e = sb.pop_front();
        chk("h", int'(h), int'(e.h));
        chk("s", int'(s), int'(e.s));
        chk("v", int'(v), int'(e.v));
        $display("pixel (%0d,%0d,%0d) -> h=%0d s=%0d v=%0d latency=%0d", pr, pg, pb, h, s, v, n);
        if (stall) begin
            for (int i = 0; i < 10; i++) begin
                in_valid = 1'b1;
                r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
                step();
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_ready", int'(in_ready), 0);
                chk("stall_h", int'(h), int'(e.h));
                chk("stall_s", int'(s), int'(e.s));
                chk("stall_v", int'(v), int'(e.v));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        step();
        exp_cnt++;
        chk("pix_cnt", int'(pix_cnt), exp_cnt);
        chk("post_in_ready", int'(in_ready), 1);
        chk("post_out_valid", int'(out_valid), 0);
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_h", int'(h), 0);
        chk("rst_s", int'(s), 0);
        chk("rst_v", int'(v), 0);
        chk("rst_pix_cnt", int'(pix_cnt), 0);
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        chk_reset_state();

        run_pixel(8'd255, 8'd0,   8'd0,   1'b0);
        run_pixel(8'd0,   8'd255, 8'd0,   1'b0);
        run_pixel(8'd0,   8'd0,   8'd255, 1'b0);
        run_pixel(8'd255, 8'd0,   8'd128, 1'b0);
        run_pixel(8'd128, 8'd128, 8'd128, 1'b0);
        run_pixel(8'd0,   8'd0,   8'd0,   1'b0);
        run_pixel(8'd128, 8'd64,  8'd0,   1'b0);
        run_pixel(8'd255, 8'd255, 8'd255, 1'b0);
        run_pixel(8'd10,  8'd200, 8'd90,  1'b0);
        run_pixel(8'd30,  8'd60,  8'd250, 1'b0);
        for (int i = 0; i < 6; i++)
            run_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);

        run_pixel(8'd200, 8'd100, 8'd50, 1'b1);

        // Reset in the middle of the hue division
        r = 8'd77; g = 8'd33; b = 8'd199; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (12) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        $display("reset applied mid-division");
        chk_reset_state();
        repeat (60) begin
            step();
            total++;
            assert (out_valid === 1'b0) else begin
                bad++;
                $error("FAIL discarded_result observed=%0d expected=0", out_valid);
            end
        end

        run_pixel(8'd255, 8'd0, 8'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
